signcompression: RTL

Sequential sign-compression unit: accepts a wide two's-complement word, counts its redundant sign bits one bit per cycle, and returns the value narrowed to a smaller width. Overflow is flagged, and the result is optionally saturated. It is the narrowing counterpart of the datapath's sign-extension stage. It sits on the store/write-back path wherever a wide ALU result must be packed into a narrower field.

---
 rtl/signcompression.sv | 127 ++++++++++++
 1 files changed

// File: rtl/signcompression.sv
// rtl/signcompression.sv - sequential sign-bit counter that narrows a wide signed word
module signcompression #(
  parameter int WIDESize   = 16,
  parameter int NARROWSize = 8,
  parameter int CNTSize    = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [WIDESize-1:0]   INPUT,
  input  logic                  SATURATE,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [NARROWSize-1:0] OUTPUT,
  output logic                  FITS,
  output logic [CNTSize-1:0]    SIGNBITS
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    FIN  = 2'd2
  } state_t;

  // Saturation limits: 1 followed by zeros (min negative) and its complement.
  localparam logic [NARROWSize-1:0] MINNEG = NARROWSize'(1) << (NARROWSize - 1);
  localparam logic [NARROWSize-1:0] MAXPOS = ~MINNEG;

  // The last scan step is the one examining bit 0; after it S is WIDESize-1.
  localparam logic [CNTSize-1:0] LASTSTEP = CNTSize'(WIDESize - 2);

  // Minimum redundant sign-bit count for the value to fit the narrow field.
  localparam logic [CNTSize-1:0] FITMIN = CNTSize'(WIDESize - NARROWSize);

  state_t                  state;
  logic                    msb;
  logic                    sat_q;
  logic [NARROWSize-1:0]   low_q;
  logic [WIDESize-2:0]     shreg;
  logic [CNTSize-1:0]      cnt;

  logic                    bit_eq;
  logic                    stop;
  logic [CNTSize-1:0]      s_next;
  logic                    fits_next;
  logic [NARROWSize-1:0]   out_next;

  // shreg holds the not-yet-examined bits below the MSB, top bit is the one under test.
  // s_next is the count as it stands after the current step, which is what
  // FIN publishes when this step ends the scan.
  always_comb begin
    bit_eq    = 1'b0;
    stop      = 1'b0;
    s_next    = cnt;
    fits_next = 1'b0;
    out_next  = low_q;

    bit_eq    = (shreg[WIDESize-2] == msb);
    stop      = !bit_eq || (cnt == LASTSTEP);
    s_next    = bit_eq ? cnt + CNTSize'(1) : cnt;
    fits_next = (s_next >= FITMIN);

    if (!fits_next && sat_q) begin
      out_next = msb ? MINNEG : MAXPOS;
    end else begin
      out_next = low_q;
    end
  end

  // Control FSM with registered status and result outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      msb      <= 1'b0;
      sat_q    <= 1'b0;
      low_q    <= '0;
      shreg    <= '0;
      cnt      <= '0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      OUTPUT   <= '0;
      FITS     <= 1'b0;
      SIGNBITS <= '0;
    end else begin
      case (state)
        IDLE, FIN: begin
          // DONE is only ever a single-cycle pulse; a START here still
          // lets the finishing operation's pulse complete this cycle.
          DONE <= 1'b0;
          if (START) begin
            msb   <= INPUT[WIDESize-1];
            sat_q <= SATURATE;
            low_q <= INPUT[NARROWSize-1:0];
            shreg <= INPUT[WIDESize-2:0];
            cnt   <= '0;
            BUSY  <= 1'b1;
            state <= SCAN;
          end else begin
            BUSY  <= 1'b0;
            state <= IDLE;
          end
        end

        SCAN: begin
          cnt <= s_next;
          if (stop) begin
            BUSY     <= 1'b0;
            DONE     <= 1'b1;
            SIGNBITS <= s_next;
            FITS     <= fits_next;
            OUTPUT   <= out_next;
            state    <= FIN;
          end else begin
            shreg <= shreg << 1;
          end
        end

        default: begin
          BUSY  <= 1'b0;
          DONE  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
